clint_axi: RTL and testbench

- Core-local interruptor (CLINT) for a single hart, built as an AXI4 slave on the CPU's uncached peripheral (DP) port.
- Holds msip, mtimecmp and the free-running 64-bit mtime counter.
- Drives the CPU's timer_intr and sftwr_intr inputs, and exports mtime so the CPU wrapper feeds rdtime from the same counter.

---
 rtl/clint_axi.sv | 183 ++++++++++++++++++
 tb/tb_clint_axi.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/clint_axi.sv
// Single-hart core-local interruptor on an AXI4 slave port.
// Holds msip, mtimecmp and the free-running mtime counter.
module clint_axi #(
  parameter int TIMER_DIV = 1,
  parameter int OFFSET_W  = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        s_awvalid,
  output logic        s_awready,
  input  logic [31:0] s_awaddr,
  input  logic        s_wvalid,
  output logic        s_wready,
  input  logic [63:0] s_wdata,
  input  logic [7:0]  s_wstrb,
  input  logic        s_wlast,
  output logic        s_bvalid,
  input  logic        s_bready,
  output logic [1:0]  s_bresp,
  input  logic        s_arvalid,
  output logic        s_arready,
  input  logic [31:0] s_araddr,
  output logic        s_rvalid,
  input  logic        s_rready,
  output logic [63:0] s_rdata,
  output logic [1:0]  s_rresp,
  output logic        s_rlast,
  output logic [63:0] mtime,
  output logic        timer_intr,
  output logic        sftwr_intr
);

  localparam int PW = (TIMER_DIV > 1) ? $clog2(TIMER_DIV) : 1;
  localparam int AW = OFFSET_W - 3;
  localparam logic [AW-1:0] A_MSIP = AW'(32'h0000_0000 >> 3);
  localparam logic [AW-1:0] A_CMP  = AW'(32'h0000_4000 >> 3);
  localparam logic [AW-1:0] A_TIME = AW'(32'h0000_BFF8 >> 3);

  logic          r_aw_held;
  logic          r_w_held;
  logic [AW-1:0] r_aw_word;
  logic [63:0]   r_wdata;
  logic [7:0]    r_wstrb;
  logic          r_bvalid;
  logic [1:0]    r_bresp;
  logic          r_rvalid;
  logic [63:0]   r_rdata;
  logic [1:0]    r_rresp;
  logic          r_msip;
  logic [63:0]   r_mtimecmp;
  logic [63:0]   r_mtime;
  logic [PW-1:0] r_presc;
  logic          r_timer_intr;
  logic          r_sftwr_intr;

  logic          w_aw_hs;
  logic          w_w_hs;
  logic          w_ar_hs;
  logic          w_commit;
  logic          w_tick;
  logic          w_wr_msip;
  logic          w_wr_cmp;
  logic          w_wr_time;
  logic [1:0]    w_wr_resp;
  logic [63:0]   w_bmask;
  logic [63:0]   w_mtime_inc;
  logic [AW-1:0] w_ar_word;
  logic [63:0]   w_rd_val;
  logic [1:0]    w_rd_resp;
  logic          w_unused;

  assign s_awready  = !r_aw_held && !r_bvalid;
  assign s_wready   = !r_w_held && !r_bvalid;
  assign s_bvalid   = r_bvalid;
  assign s_bresp    = r_bresp;
  assign s_arready  = !r_rvalid;
  assign s_rvalid   = r_rvalid;
  assign s_rdata    = r_rdata;
  assign s_rresp    = r_rresp;
  assign s_rlast    = r_rvalid;
  assign mtime      = r_mtime;
  assign timer_intr = r_timer_intr;
  assign sftwr_intr = r_sftwr_intr;

  // Upper address bits are pre-decoded by the interconnect.
  assign w_unused = ^{s_wlast, s_awaddr[31:OFFSET_W], s_awaddr[2:0],
                      s_araddr[31:OFFSET_W], s_araddr[2:0]};

  assign w_aw_hs  = s_awvalid && s_awready;
  assign w_w_hs   = s_wvalid && s_wready;
  assign w_ar_hs  = s_arvalid && s_arready;
  assign w_commit = r_aw_held && r_w_held;
  assign w_tick   = (r_presc == PW'(TIMER_DIV - 1));

  assign w_wr_msip = w_commit && (r_aw_word == A_MSIP);
  assign w_wr_cmp  = w_commit && (r_aw_word == A_CMP);
  assign w_wr_time = w_commit && (r_aw_word == A_TIME);
  assign w_wr_resp = ((r_aw_word == A_MSIP) || (r_aw_word == A_CMP) ||
                      (r_aw_word == A_TIME)) ? 2'b00 : 2'b10;

  assign w_mtime_inc = w_tick ? r_mtime + 64'd1 : r_mtime;
  assign w_ar_word   = s_araddr[OFFSET_W-1:3];

  always_comb begin
    w_bmask = '0;
    for (int k = 0; k < 8; k++) begin
      w_bmask[8*k +: 8] = {8{r_wstrb[k]}};
    end
  end

  always_comb begin
    w_rd_val  = '0;
    w_rd_resp = 2'b00;
    unique case (1'b1)
      (w_ar_word == A_MSIP): w_rd_val = {63'd0, r_msip};
      (w_ar_word == A_CMP):  w_rd_val = r_mtimecmp;
      (w_ar_word == A_TIME): w_rd_val = r_mtime;
      default:               w_rd_resp = 2'b10;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_aw_held    <= 1'b0;
      r_w_held     <= 1'b0;
      r_aw_word    <= '0;
      r_wdata      <= '0;
      r_wstrb      <= '0;
      r_bvalid     <= 1'b0;
      r_bresp      <= 2'b00;
      r_rvalid     <= 1'b0;
      r_rdata      <= '0;
      r_rresp      <= 2'b00;
      r_msip       <= 1'b0;
      r_mtimecmp   <= '1;
      r_mtime      <= '0;
      r_presc      <= '0;
      r_timer_intr <= 1'b0;
      r_sftwr_intr <= 1'b0;
    end else begin
      if (w_aw_hs) begin
        r_aw_held <= 1'b1;
        r_aw_word <= s_awaddr[OFFSET_W-1:3];
      end
      if (w_w_hs) begin
        r_w_held <= 1'b1;
        r_wdata  <= s_wdata;
        r_wstrb  <= s_wstrb;
      end
      if (w_commit) begin
        r_aw_held <= 1'b0;
        r_w_held  <= 1'b0;
        r_bvalid  <= 1'b1;
        r_bresp   <= w_wr_resp;
      end else if (r_bvalid && s_bready) begin
        r_bvalid <= 1'b0;
      end

      if (w_ar_hs) begin
        r_rvalid <= 1'b1;
        r_rdata  <= w_rd_val;
        r_rresp  <= w_rd_resp;
      end else if (r_rvalid && s_rready) begin
        r_rvalid <= 1'b0;
      end

      r_presc <= w_tick ? '0 : r_presc + PW'(1);
      // Written bytes override the tick; the rest keep counting.
      r_mtime <= w_wr_time ? ((w_mtime_inc & ~w_bmask) | (r_wdata & w_bmask))
                           : w_mtime_inc;
      if (w_wr_cmp) begin
        r_mtimecmp <= (r_mtimecmp & ~w_bmask) | (r_wdata & w_bmask);
      end
      if (w_wr_msip && r_wstrb[0]) begin
        r_msip <= r_wdata[0];
      end

      r_timer_intr <= (r_mtime >= r_mtimecmp);
      r_sftwr_intr <= r_msip;
    end
  end

endmodule

// File: tb/tb_clint_axi.sv
// Directed bench for clint_axi: a TIMER_DIV=1 instance plus a
// TIMER_DIV=4 instance sharing the same bus stimulus.
module tb_clint_axi;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        awvalid = 1'b0;
  logic [31:0] awaddr = '0;
  logic        wvalid = 1'b0;
  logic [63:0] wdata = '0;
  logic [7:0]  wstrb = '0;
  logic        wlast = 1'b1;
  logic        bready = 1'b0;
  logic        arvalid = 1'b0;
  logic [31:0] araddr = '0;
  logic        rready = 1'b0;

  logic        awready, wready, bvalid, arready, rvalid, rlast;
  logic [1:0]  bresp, rresp;
  logic [63:0] rdata, mtime;
  logic        tintr, sintr;

  logic        awready4, wready4, bvalid4, arready4, rvalid4, rlast4;
  logic [1:0]  bresp4, rresp4;
  logic [63:0] rdata4, mtime4;
  logic        tintr4, sintr4;

  int n_vec = 0;
  int n_err = 0;

  logic [63:0] d;
  logic [1:0]  r;
  logic        l;

  always #5 clk = ~clk;

  clint_axi #(.TIMER_DIV(1), .OFFSET_W(16)) u_dut (
    .clk(clk), .reset(reset),
    .s_awvalid(awvalid), .s_awready(awready), .s_awaddr(awaddr),
    .s_wvalid(wvalid), .s_wready(wready), .s_wdata(wdata),
    .s_wstrb(wstrb), .s_wlast(wlast),
    .s_bvalid(bvalid), .s_bready(bready), .s_bresp(bresp),
    .s_arvalid(arvalid), .s_arready(arready), .s_araddr(araddr),
    .s_rvalid(rvalid), .s_rready(rready), .s_rdata(rdata),
    .s_rresp(rresp), .s_rlast(rlast),
    .mtime(mtime), .timer_intr(tintr), .sftwr_intr(sintr)
  );

  clint_axi #(.TIMER_DIV(4), .OFFSET_W(16)) u_div4 (
    .clk(clk), .reset(reset),
    .s_awvalid(awvalid), .s_awready(awready4), .s_awaddr(awaddr),
    .s_wvalid(wvalid), .s_wready(wready4), .s_wdata(wdata),
    .s_wstrb(wstrb), .s_wlast(wlast),
    .s_bvalid(bvalid4), .s_bready(bready), .s_bresp(bresp4),
    .s_arvalid(arvalid), .s_arready(arready4), .s_araddr(araddr),
    .s_rvalid(rvalid4), .s_rready(rready), .s_rdata(rdata4),
    .s_rresp(rresp4), .s_rlast(rlast4),
    .mtime(mtime4), .timer_intr(tintr4), .sftwr_intr(sintr4)
  );

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [31:0] a, input logic [63:0] dv,
                    input logic [7:0] s);
    awvalid = 1'b1; awaddr = a;
    wvalid = 1'b1; wdata = dv; wstrb = s;
    step();
    awvalid = 1'b0; wvalid = 1'b0;
    chk("wr_b_early", bvalid, 0);
    step();
    chk("wr_bvalid", bvalid, 1);
  endtask

  task automatic back();
    bready = 1'b1;
    step();
    bready = 1'b0;
  endtask

  task automatic rd(input logic [31:0] a, output logic [63:0] dv,
                    output logic [1:0] rs, output logic lst);
    arvalid = 1'b1; araddr = a;
    step();
    arvalid = 1'b0;
    chk("rd_rvalid", rvalid, 1);
    dv = rdata; rs = rresp; lst = rlast;
    rready = 1'b1;
    step();
    rready = 1'b0;
  endtask

  initial begin
    step(); step(); step();
    chk("rst_awready", awready, 1);
    chk("rst_wready", wready, 1);
    chk("rst_arready", arready, 1);
    chk("rst_bvalid", bvalid, 0);
    chk("rst_rvalid", rvalid, 0);
    chk("rst_mtime", mtime, 0);
    reset = 1'b0;
    for (int i = 0; i < 5; i++) step();
    chk("idle_mtime", mtime, 5);
    chk("idle_mtime4", mtime4, 1);
    chk("idle_tintr", tintr, 0);
    chk("idle_sintr", sintr, 0);
    chk("idle_ready", {awready, wready, arready}, 3'b111);

    // W three cycles ahead of AW
    wvalid = 1'b1; wdata = 64'h1; wstrb = 8'h01;
    step();
    wvalid = 1'b0;
    chk("w_held_wready", wready, 0);
    chk("w_held_awready", awready, 1);
    step(); step();
    awvalid = 1'b1; awaddr = 32'h0;
    step();
    awvalid = 1'b0;
    chk("msip_b_early", bvalid, 0);
    step();
    chk("msip_bvalid", bvalid, 1);
    chk("msip_bresp", bresp, 0);
    chk("msip_sintr_lag", sintr, 0);
    back();
    chk("msip_sintr", sintr, 1);
    chk("msip_bdone", bvalid, 0);
    rd(32'h0, d, r, l);
    chk("msip_rdata", d, 1);
    chk("msip_rresp", r, 0);
    chk("msip_rlast", l, 1);

    // compare against a running mtime
    wr(32'hBFF8, 64'h0, 8'hFF); back();
    wr(32'h4000, 64'd20, 8'hFF); back();
    chk("cmp_tintr_lo", tintr, 0);
    for (int i = 0; i < 64 && mtime != 64'd20; i++) step();
    chk("cmp_mtime20", mtime, 20);
    chk("cmp_tintr_lag", tintr, 0);
    step();
    chk("cmp_tintr_hi", tintr, 1);
    chk("cmp_mtime21", mtime, 21);
    wr(32'h4000, '1, 8'hFF);
    chk("cmpmax_tintr_lag", tintr, 1);
    back();
    chk("cmpmax_tintr", tintr, 0);

    // byte-masked mtime write on a tick from 0x1FF
    wr(32'hBFF8, 64'h1FD, 8'hFF); back();
    wr(32'hBFF8, 64'hAABB, 8'h03);
    chk("mask_mtime", mtime, 64'hAABB);
    back();
    chk("mask_count", mtime, 64'hAABC);

    // unmapped word and a stalled B channel
    rd(32'h0100, d, r, l);
    chk("unm_rresp", r, 2'b10);
    chk("unm_rdata", d, 0);
    wr(32'h0100, '1, 8'hFF);
    for (int i = 0; i < 4; i++) begin
      chk("stall_bvalid", bvalid, 1);
      chk("stall_bresp", bresp, 2'b10);
      chk("stall_ready", {awready, wready}, 2'b00);
      step();
    end
    back();
    rd(32'h4000, d, r, l);
    chk("unm_cmp_kept", d, '1);
    rd(32'h0000, d, r, l);
    chk("unm_msip_kept", d, 1);

    // TIMER_DIV=4 wrap
    wr(32'hBFF8, '1, 8'hFF);
    chk("wrap4_max", mtime4, '1);
    chk("wrap1_max", mtime, '1);
    back();
    chk("wrap1_zero", mtime, 0);
    chk("wrap4_tintr", tintr4, 1);
    step(); step(); step();
    chk("wrap4_zero", mtime4, 0);
    step();
    chk("wrap4_tintr_lo", tintr4, 0);

    // reset drops a held W beat
    wvalid = 1'b1; wdata = 64'h0; wstrb = 8'hFF;
    step();
    wvalid = 1'b0;
    chk("mid_wheld", wready, 0);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("mid_wready", wready, 1);
    chk("mid_bvalid", bvalid, 0);
    chk("mid_sintr", sintr, 0);
    chk("mid_mtime", mtime, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
